// File: rtl/alu_issuer_pkg.sv
// Shared opcode and FSM state encodings for the ALU command issuer.
package alu_issuer_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Bit 0 = add, bit 1 = sub, bit 2 = mul, bit 3 = div.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        return 4'b0001 << op;
    endfunction

endpackage

// File: rtl/alu_issuer_fifo.sv
// Synchronous command queue; DEPTH must be a power of two and at least 2.
module alu_issuer_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full queue refuses the push even when a pop frees a slot this cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issuer.sv
// Queues ALU commands and issues them one at a time to a sequential ALU, returning results in order.
// Define ALU_ISSUER_STATS_EN to add the o_stat_ops/o_stat_ovf result counters.
module alu_issuer
    import alu_issuer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_a,
    input  logic [DATA_WIDTH-1:0] i_cmd_b,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic                  o_alu_add,
    output logic                  o_alu_sub,
    output logic                  o_alu_mul,
    output logic                  o_alu_div,
    input  logic [DATA_WIDTH-1:0] i_alu_q,
    input  logic                  i_alu_ovf,
    input  logic                  i_alu_accept,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [DATA_WIDTH-1:0] o_res_q,
    output logic                  o_res_ovf,
    output logic [1:0]            o_res_op,
    output logic                  o_busy
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]           o_stat_ops,
    output logic [15:0]           o_stat_ovf
`endif
);

    localparam int unsigned CW = 2*DATA_WIDTH + 2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res_q;
    logic                  r_res_ovf;
    logic [1:0]            r_res_op;

    logic [CW-1:0]         w_cmd_word;
    logic [CW-1:0]         w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_res_done;
    logic [3:0]            w_op_lines;

    assign w_cmd_word = {i_cmd_op, i_cmd_a, i_cmd_b};
    assign w_push     = i_cmd_valid && !w_full;
    assign w_accept   = (r_state == ST_ISSUE) && i_alu_accept;
    assign w_res_done = (r_state == ST_HOLD) && i_res_ready;
    // The head is loaded from IDLE or straight out of HOLD so back-to-back work skips IDLE.
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_res_done);

    alu_issuer_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (w_push),
        .i_data  (w_cmd_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_alu_accept) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_res_ready) begin
                    w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res_q   <= '0;
            r_res_ovf <= 1'b0;
            r_res_op  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                {r_op, r_a, r_b} <= w_head;
            end
            if (w_accept) begin
                r_res_q   <= i_alu_q;
                r_res_ovf <= i_alu_ovf;
                r_res_op  <= r_op;
            end
        end
    end

    assign w_op_lines  = (r_state == ST_ISSUE) ? op_onehot(r_op) : '0;
    assign o_alu_add   = w_op_lines[OP_ADD];
    assign o_alu_sub   = w_op_lines[OP_SUB];
    assign o_alu_mul   = w_op_lines[OP_MUL];
    assign o_alu_div   = w_op_lines[OP_DIV];
    assign o_alu_a     = r_a;
    assign o_alu_b     = r_b;
    assign o_cmd_ready = !w_full;
    assign o_res_valid = (r_state == ST_HOLD);
    assign o_res_q     = r_res_q;
    assign o_res_ovf   = r_res_ovf;
    assign o_res_op    = r_res_op;
    assign o_busy      = !w_empty || (r_state != ST_IDLE);

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_ovf;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_stat_ops <= '0;
            r_stat_ovf <= '0;
        end else if (w_res_done) begin
            if (r_stat_ops != '1) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_res_ovf && (r_stat_ovf != '1)) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
        end
    end

    assign o_stat_ops = r_stat_ops;
    assign o_stat_ovf = r_stat_ovf;
`endif

endmodule
